imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//   Fetch sequencer for the word-addressed instruction memory (async-read array).
//   Owns the PC, drives the memory address and pushes {pc,instr} into a 2-entry
//   queue toward decode with a valid/ready handshake.
//   Handles branch redirects and flush, and halts on out-of-range PC.
//   Optionally shares the memory port with a boot-time program loader.
// PARAMETERS
//   ADDR_W    32   PC / memory address width (word index, not byte address)
//   DATA_W    32   instruction width
//   DEPTH     100  number of valid memory words; legal PC range 0..DEPTH-1
//   RESET_PC  0    PC loaded on reset
// PORTS
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high
//   redirect_valid in   1       branch/jump redirect strobe
//   redirect_pc    in   ADDR_W  redirect target (word index)
//   out_valid      out  1       instruction available to decode
//   out_ready      in   1       decode accepts; transfer when valid&ready
//   out_instr      out  DATA_W  head-of-queue instruction
//   out_pc         out  ADDR_W  PC of out_instr
//   fault          out  1       sticky: PC left 0..DEPTH-1
//   mem_addr       out  ADDR_W  memory address (combinational read)
//   mem_rdata      in   DATA_W  memory read data, same cycle as mem_addr
//   mem_we         out  1       memory write enable (loader only)
//   mem_wdata      out  DATA_W  memory write data
//   ld_valid       in   1       loader write request
//   ld_ready       out  1       loader write accepted this cycle
//   ld_addr        in   ADDR_W  loader word address
//   ld_data        in   DATA_W  loader word
// BEHAVIOUR
//   Reset values: pc=RESET_PC, state=BOOT, queue empty, out_valid=0,
//     out_instr=0, out_pc=0, fault=0, mem_we=0, ld_ready=0.
//   FSM BOOT -> RUN after one cycle; RUN -> HALT when pc >= DEPTH at a fetch
//     attempt; HALT -> RUN on a redirect to an in-range target; reset wins in every state.
//   Fetch in RUN: issued when no redirect, no loader grant, pc < DEPTH and
//     (queue not full or pop this cycle); mem_addr=pc; {pc,mem_rdata} pushed at
//     the edge; pc<=pc+1. First out_valid=1 is the 2nd cycle after reset drops.
//   Throughput: 1 instr/cycle with out_ready held high; full queue (2) stalls
//     the PC, which holds its value; no entry is lost or duplicated.
//   Redirect: same cycle handshake (valid&ready) completes first, then queue
//     flushed, pc<=redirect_pc, no push; out_valid=0 the next cycle; first
//     target instruction valid 2 cycles after the redirect cycle.
//   Target >= DEPTH: enter HALT, fault=1; fault clears on an in-range redirect.
//   HALT: no fetch; the queue still drains entries fetched before the fault.
//   pc+1 wraps at 2^ADDR_W (out of range anyway -> HALT).
//   mem_addr = pc when no loader grant (stable, even when idle).
// CONFIGURATION
//   IMEM_LOADER_EN defined: loader has priority for the memory port in every
//     state; ld_ready=ld_valid; mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data;
//     fetch stalls that cycle, pc unchanged; redirect still applied.
//     ld_addr >= DEPTH: acked, mem_we=0 (write dropped).
//   Not defined: ld_* ignored, ld_ready=0, mem_we=0, mem_wdata=0; ports remain.
// STRUCTURE
//   imem_pkg: state enum {BOOT,RUN,HALT}, fetch_entry_t {pc,instr}, defaults
//     IMEM_DEPTH=100, IMEM_RESET_PC=0.
//   Sub-module fetch_queue: 2-entry FIFO of fetch_entry_t with push/pop/flush,
//     full/empty flags; flush overrides push, pop is applied before flush.
// TESTING
//   Reset, out_ready=1 -> out_pc 0,1,2... one per cycle from the 2nd post-reset cycle, instr=mem[pc].
//   Hold out_ready=0 for 5 cycles -> queue holds pc 0,1; pc stalls at 2; release -> 0,1,2,3 in order.
//   Redirect to 40 at pc=7 with a pop in the same cycle -> popped entry kept, next outputs 40,41.
//   Run to pc=DEPTH-1 -> after pc 99 is delivered fault=1, out_valid=0; redirect to 5 -> fault=0, pc 5 out.
//   IMEM_LOADER_EN: ld writes 0x13 to addr 3 during RUN -> fetch stalls 1 cycle; later fetch of 3 returns 0x13.
//   Reset asserted mid-stream with a full queue -> next cycle out_valid=0, fault=0, restart at RESET_PC.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-fetch slice: FSM states,
// queue entry layout and default memory geometry.
package imem_pkg;

  localparam int              IMEM_ADDR_W   = 32;
  localparam int              IMEM_DATA_W   = 32;
  localparam int              IMEM_DEPTH    = 100;
  localparam logic [31:0]     IMEM_RESET_PC = 32'd0;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] pc;
    logic [IMEM_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Two-entry FIFO of fetch entries between the fetch sequencer and decode.
// A pop completes before a flush clears the queue; flush overrides push.
module fetch_queue
  import imem_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         pop_ok;
  logic         push_ok;
  fetch_entry_t slot0;
  fetch_entry_t slot1;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = slot0;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = 2'd0;
    end else if (push_ok && !pop_ok) begin
      count_next = count + 2'd1;
    end else if (pop_ok && !push_ok) begin
      count_next = count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      count <= count_next;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (pop_ok) begin
        slot0 <= slot1;
        if (push_ok) begin
          if (count == 2'd1) begin
            slot0 <= push_entry;
          end else begin
            slot1 <= push_entry;
          end
        end
      end else if (push_ok) begin
        if (count == 2'd0) begin
          slot0 <= push_entry;
        end else begin
          slot1 <= push_entry;
        end
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the async instruction memory
// and queues {pc,instr} toward decode. Define IMEM_LOADER_EN to let a boot loader share the memory port.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                DEPTH    = IMEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = IMEM_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              fault_next;
  logic              fetch;
  logic              flush;
  logic              pop;
  logic              ld_grant;
  logic              q_full;
  logic              q_empty;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

`ifdef IMEM_LOADER_EN
  // Loader owns the memory port whenever it asks; out-of-range writes are acked but dropped.
  assign ld_grant  = ld_valid & ~reset;
  assign ld_ready  = ld_grant;
  assign mem_we    = ld_grant & (ld_addr < DEPTH_A);
  assign mem_wdata = ld_grant ? ld_data : '0;
  assign mem_addr  = ld_grant ? ld_addr : pc;
`else
  logic ld_unused;
  assign ld_unused = ^{ld_valid, ld_addr, ld_data};
  assign ld_grant  = 1'b0;
  assign ld_ready  = 1'b0;
  assign mem_we    = 1'b0;
  assign mem_wdata = '0;
  assign mem_addr  = pc;
`endif

  assign pop              = ~q_empty & out_ready;
  assign push_entry.pc    = pc;
  assign push_entry.instr = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

  // Redirect beats fetch; a loader grant or a full queue without a pop stalls the PC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    fault_next = fault;
    fetch      = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_next = redirect_pc;
      if (redirect_pc < DEPTH_A) begin
        state_next = RUN;
        fault_next = 1'b0;
      end else begin
        state_next = HALT;
        fault_next = 1'b1;
      end
    end else begin
      case (state)
        BOOT: state_next = RUN;
        RUN: begin
          if (!ld_grant) begin
            if (pc >= DEPTH_A) begin
              state_next = HALT;
              fault_next = 1'b1;
            end else if (!q_full || pop) begin
              fetch   = 1'b1;
              pc_next = pc + ADDR_W'(1);
            end
          end
        end
        HALT: state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (fetch),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign out_valid = ~q_empty;
  assign out_pc    = q_empty ? '0 : head.pc;
  assign out_instr = q_empty ? '0 : head.instr;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural async-read memory
// preloaded with instr = 0xA000_0000 + address.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0] mem [0:127];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;
  end

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first post-reset (BOOT) cycle.
  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    ld_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    ld_valid = 1'b1;
    ld_addr = 32'd3;
    ld_data = 32'h55;
    cyc();
    cyc();
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b pc=%0d instr=%h required 0/0/0", out_valid, out_pc, out_instr);
    end
    n_checks++;
    if (fault !== 1'b0 || mem_we !== 1'b0 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: fault=%b mem_we=%b ld_ready=%b required 0/0/0", fault, mem_we, ld_ready);
    end
    n_checks++;
    if (mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mem_addr: got %0d required 0", mem_addr);
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    cyc();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_first_cycle_valid: got %b required 0", out_valid);
    end
    cyc();
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== 32'hA000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL stream_%0d: valid=%b pc=%0d instr=%h required 1/%0d/%h",
                 i, out_valid, out_pc, out_instr, i, 32'hA000_0000 + 32'(i));
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b pc=%0d required 1/0", out_valid, out_pc);
    end
    n_checks++;
    if (mem_addr !== 32'd2) begin
      n_fail++;
      $display("FAIL bp_pc_stall: mem_addr=%0d required 2", mem_addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== 32'hA000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_release_%0d: valid=%b pc=%0d required 1/%0d", i, out_valid, out_pc, i);
      end
      cyc();
    end
  endtask

  task automatic test_redirect_and_halt();
    int e;
    do_reset();
    out_ready = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 7; i++) cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd7) begin
      n_fail++;
      $display("FAIL redir_popped_entry: valid=%b pc=%0d required 1/7", out_valid, out_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd40;
    cyc();
    redirect_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_bubble: valid=%b required 0", out_valid);
    end
    cyc();
    for (int i = 40; i < 42; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i) || out_instr !== 32'hA000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL redir_target_%0d: valid=%b pc=%0d required 1/%0d", i, out_valid, out_pc, i);
      end
      cyc();
    end
    e = 42;
    while (e < 100) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(e)) begin
        n_fail++;
        $display("FAIL run_to_end_%0d: valid=%b pc=%0d", e, out_valid, out_pc);
      end
      e++;
      cyc();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_at_depth: valid=%b fault=%b required 0/1", out_valid, fault);
    end
    cyc();
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || fault !== 1'b1 || mem_addr !== 32'd100) begin
      n_fail++;
      $display("FAIL halt_hold: valid=%b fault=%b addr=%0d required 0/1/100", out_valid, fault, mem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd5;
    cyc();
    redirect_valid = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_recover: fault=%b valid=%b required 0/0", fault, out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd5 || out_instr !== 32'hA000_0005) begin
      n_fail++;
      $display("FAIL halt_recover_pc: valid=%b pc=%0d required 1/5", out_valid, out_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd100;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    n_checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_oob: fault=%b valid=%b required 1/0", fault, out_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'd99;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    n_checks++;
    if (fault !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'd99) begin
      n_fail++;
      $display("FAIL redir_last_word: fault=%b valid=%b pc=%0d required 0/1/99", fault, out_valid, out_pc);
    end
    cyc();
    n_checks++;
    if (fault !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_after_last: fault=%b valid=%b required 1/0", fault, out_valid);
    end
  endtask

  task automatic test_loader();
    do_reset();
    out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    // Steady stream: out_pc = 2 here, PC = 3.
    ld_valid = 1'b1;
    ld_addr = 32'd3;
    ld_data = 32'h13;
    #1;
`ifdef IMEM_LOADER_EN
    n_checks++;
    if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd3 || mem_wdata !== 32'h13) begin
      n_fail++;
      $display("FAIL ld_grant: ready=%b we=%b addr=%0d wdata=%h required 1/1/3/13", ld_ready, mem_we, mem_addr, mem_wdata);
    end
    cyc();
    ld_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_stall_bubble: valid=%b required 0", out_valid);
    end
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd3 || out_instr !== 32'h13) begin
      n_fail++;
      $display("FAIL ld_fetch_written: valid=%b pc=%0d instr=%h required 1/3/13", out_valid, out_pc, out_instr);
    end
    ld_valid = 1'b1;
    ld_addr = 32'd100;
    ld_data = 32'h77;
    #1;
    n_checks++;
    if (ld_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_oob: ready=%b we=%b required 1/0", ld_ready, mem_we);
    end
    cyc();
    ld_valid = 1'b0;
    n_checks++;
    if (mem[100] !== 32'hA000_0064) begin
      n_fail++;
      $display("FAIL ld_oob_dropped: mem[100]=%h required a0000064", mem[100]);
    end
`else
    n_checks++;
    if (ld_ready !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'd0 || mem_addr !== 32'd3) begin
      n_fail++;
      $display("FAIL ld_ignored: ready=%b we=%b wdata=%h addr=%0d required 0/0/0/3", ld_ready, mem_we, mem_wdata, mem_addr);
    end
    cyc();
    ld_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd3 || out_instr !== 32'hA000_0003) begin
      n_fail++;
      $display("FAIL ld_ignored_stream: valid=%b pc=%0d instr=%h required 1/3/a0000003", out_valid, out_pc, out_instr);
    end
`endif
  endtask

  task automatic test_reset_midstream();
    do_reset();
    out_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || mem_addr !== 32'd2) begin
      n_fail++;
      $display("FAIL mid_full: valid=%b pc=%0d addr=%0d required 1/0/2", out_valid, out_pc, mem_addr);
    end
    reset = 1'b1;
    cyc();
    n_checks++;
    if (out_valid !== 1'b0 || fault !== 1'b0 || mem_addr !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b fault=%b addr=%0d required 0/0/0", out_valid, fault, mem_addr);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i)) begin
        n_fail++;
        $display("FAIL mid_restart_%0d: valid=%b pc=%0d required 1/%0d", i, out_valid, out_pc, i);
      end
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_and_halt();
    test_loader();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
